// File: rtl/jump_charge_ctrl.sv
// jump_charge_ctrl: debounced button hold -> charge velocity and squeeze, one-cycle jump pulse, landing wait.
// Define JUMP_CHARGE_CTRL_OVERCHARGE_EN to auto-launch after OVERCHARGE_TICKS ticks at V_MAX.
//   state   | meaning
//   IDLE    | waiting for an enabled press
//   CHARGE  | button held, velocity and squeeze ramp per tick
//   LAUNCH  | one cycle: latch velocity, pulse o_jump_en
//   AIR     | waiting for i_jump_done or timeout
//   RECOVER | waiting for the button to be released
module jump_charge_ctrl #(
  parameter int TICK_DIV       = 251750,
  parameter int DEBOUNCE_TICKS = 2,
  parameter int V_MIN          = 8,
  parameter int V_STEP         = 2,
  parameter int V_MAX          = 200,
  parameter int SQ_TICKS       = 8,
  parameter int JUMP_TIMEOUT   = 300
`ifdef JUMP_CHARGE_CTRL_OVERCHARGE_EN
  , parameter int OVERCHARGE_TICKS = 50
`endif
) (
  input  logic       clk_jump_charge_ctrl,
  input  logic       rst_jump_charge_ctrl,
  input  logic       i_btn,
  input  logic       i_enable,
  input  logic       i_jump_done,
  output logic [7:0] o_jump_v_init,
  output logic [2:0] o_squeeze_man,
  output logic       o_jump_en,
  output logic       o_busy,
  output logic       o_timeout,
  output logic [2:0] o_state
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int AW = $clog2(JUMP_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHARGE  = 3'd1,
    LAUNCH  = 3'd2,
    AIR     = 3'd3,
    RECOVER = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          btn_s1, btn_s2, btn_db, btn_db_q;
  logic [DW-1:0] db_cnt;
  logic          btn_press, btn_rel;
  logic [7:0]    v_acc, v_nxt, n, n_nxt, sq_div;
  logic [8:0]    v_sum;
  logic [2:0]    sq_nxt;
  logic [AW-1:0] air_cnt;
  logic          air_timeout;
  logic          overcharge;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk_jump_charge_ctrl) begin
    if (rst_jump_charge_ctrl) begin
      tick_cnt <= '0;
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      btn_s1   <= i_btn;
      btn_s2   <= btn_s1;
      btn_db_q <= btn_db;
      if (tick) begin
        if (btn_s2 != btn_db) begin
          if (db_cnt == DW'(DEBOUNCE_TICKS - 1)) begin
            btn_db <= btn_s2;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end
  end

  assign btn_press = btn_db & ~btn_db_q;
  assign btn_rel   = ~btn_db & btn_db_q;

  // Charge arithmetic on 9 bits so the saturation compare cannot wrap.
  assign v_sum  = {1'b0, v_acc} + 9'(V_STEP);
  assign v_nxt  = (v_sum > 9'(V_MAX)) ? 8'(V_MAX) : v_sum[7:0];
  assign n_nxt  = (n == 8'hFF) ? n : n + 8'd1;
  assign sq_div = n_nxt / 8'(SQ_TICKS);
  assign sq_nxt = (sq_div > 8'd7) ? 3'd7 : sq_div[2:0];

  assign air_timeout = tick && (air_cnt == AW'(JUMP_TIMEOUT - 1));

`ifdef JUMP_CHARGE_CTRL_OVERCHARGE_EN
  localparam int OW = $clog2(OVERCHARGE_TICKS + 1);
  logic [OW-1:0] oc_cnt;

  assign overcharge = tick && (v_acc == 8'(V_MAX)) && (oc_cnt == OW'(OVERCHARGE_TICKS - 1));

  always_ff @(posedge clk_jump_charge_ctrl) begin
    if (rst_jump_charge_ctrl || state != CHARGE)
      oc_cnt <= '0;
    else if (tick && v_acc == 8'(V_MAX))
      oc_cnt <= oc_cnt + OW'(1);
  end
`else
  assign overcharge = 1'b0;
`endif

  always_ff @(posedge clk_jump_charge_ctrl) begin
    if (rst_jump_charge_ctrl) state <= IDLE;
    else                      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (btn_press && i_enable) state_nxt = CHARGE;
      CHARGE: begin
        if (!i_enable)                   state_nxt = IDLE;
        else if (btn_rel || overcharge)  state_nxt = LAUNCH;
      end
      LAUNCH:  state_nxt = AIR;
      AIR:     if (i_jump_done || air_timeout) state_nxt = RECOVER;
      RECOVER: if (tick && !btn_db) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Launch values are latched on entry so they line up with the o_jump_en pulse.
  always_ff @(posedge clk_jump_charge_ctrl) begin
    if (rst_jump_charge_ctrl) begin
      v_acc         <= '0;
      n             <= '0;
      air_cnt       <= '0;
      o_jump_v_init <= '0;
      o_squeeze_man <= '0;
      o_jump_en     <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      o_jump_en <= (state_nxt == LAUNCH);
      case (state)
        IDLE: begin
          o_squeeze_man <= '0;
          if (state_nxt == CHARGE) begin
            v_acc <= 8'(V_MIN);
            n     <= '0;
          end
        end
        CHARGE: begin
          if (state_nxt == IDLE) begin
            o_squeeze_man <= '0;
          end else if (state_nxt == LAUNCH) begin
            o_jump_v_init <= v_acc;
            o_squeeze_man <= '0;
            o_timeout     <= 1'b0;
          end else if (tick) begin
            n             <= n_nxt;
            v_acc         <= v_nxt;
            o_squeeze_man <= sq_nxt;
          end
        end
        LAUNCH: air_cnt <= '0;
        AIR: begin
          if (!i_jump_done && air_timeout) o_timeout <= 1'b1;
          else if (tick)                   air_cnt   <= air_cnt + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_busy  = (state != IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_jump_charge_ctrl.sv
// Directed bench for jump_charge_ctrl with a 4-cycle tick.
module tb_jump_charge_ctrl;

  logic       clk = 1'b0, rst = 1'b1, btn = 1'b0, en = 1'b0, done = 1'b0;
  logic [7:0] v_init;
  logic [2:0] squeeze, state;
  logic       jump_en, busy, timeout;

  int checks = 0, passes = 0, pulses = 0, exp_pulses = 0;
  logic [1:0] ph;
  logic       bad;

  jump_charge_ctrl #(
    .TICK_DIV(4), .DEBOUNCE_TICKS(2), .V_MIN(8), .V_STEP(2),
    .V_MAX(40), .SQ_TICKS(2), .JUMP_TIMEOUT(20)
  ) dut (
    .clk_jump_charge_ctrl(clk),
    .rst_jump_charge_ctrl(rst),
    .i_btn(btn),
    .i_enable(en),
    .i_jump_done(done),
    .o_jump_v_init(v_init),
    .o_squeeze_man(squeeze),
    .o_jump_en(jump_en),
    .o_busy(busy),
    .o_timeout(timeout),
    .o_state(state)
  );

  always #5 clk = ~clk;

  // Tick phase reference: with TICK_DIV=4 the tick edge follows the cycle where ph==3.
  always @(posedge clk) begin
    if (rst) ph <= 2'd0;
    else     ph <= ph + 2'd1;
  end

  always @(negedge clk) if (jump_en) pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) begin
      while (ph != 2'd3) @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag, input int budget);
    for (int i = 0; i < budget && state !== s; i++) @(negedge clk);
    check(tag, state, s);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    cyc(1);
    done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_en"}, jump_en, 0);
    check({tag, "_vinit"}, v_init, 0);
    check({tag, "_sq"}, squeeze, 0);
    check({tag, "_to"}, timeout, 0);
  endtask

  initial begin
    // 1. reset and idle
    cyc(3);
    rst = 1'b0;
    cyc(50);
    check_reset_outputs("reset");

    // 2. 10-tick charge: v = 8 + 2*10 = 28, squeeze = 10/2 = 5
    en  = 1'b1;
    btn = 1'b1;
    wait_state(3'd1, "t2_enter_charge", 100);
    ticks(8);
    check("t2_sq_after8", squeeze, 4);
    btn = 1'b0;
    ticks(2);
    check("t2_still_charge", state, 1);
    check("t2_sq_before_launch", squeeze, 5);
    cyc(1);
    exp_pulses++;
    check("t2_launch_state", state, 2);
    check("t2_jump_en", jump_en, 1);
    check("t2_vinit", v_init, 28);
    check("t2_sq_after_launch", squeeze, 0);
    cyc(1);
    check("t2_air", state, 3);
    check("t2_en_low", jump_en, 0);
    ticks(5);
    pulse_done();
    check("t2_recover", state, 4);
    wait_state(3'd0, "t2_idle", 20);
    check("t2_timeout", timeout, 0);
    check("t2_pulses", pulses, exp_pulses);

    // 3. 30-tick charge saturates at V_MAX, squeeze caps at 7
    btn = 1'b1;
    wait_state(3'd1, "t3_enter_charge", 100);
    ticks(28);
    check("t3_sq_cap", squeeze, 7);
    btn = 1'b0;
    ticks(2);
    cyc(1);
    exp_pulses++;
    check("t3_launch", state, 2);
    check("t3_vinit_sat", v_init, 40);
    cyc(1);
    pulse_done();
    wait_state(3'd0, "t3_idle", 20);
    check("t3_pulses", pulses, exp_pulses);

`ifdef JUMP_CHARGE_CTRL_OVERCHARGE_EN
    btn = 1'b1;
    wait_state(3'd1, "oc_enter_charge", 100);
    wait_state(3'd2, "oc_auto_launch", 400);
    exp_pulses++;
    check("oc_vinit", v_init, 40);
    cyc(1);
    pulse_done();
    cyc(20);
    check("oc_held_recover", state, 4);
    check("oc_pulses", pulses, exp_pulses);
    btn = 1'b0;
    wait_state(3'd0, "oc_idle", 40);
`endif

    // 4. single-tick glitch must not be accepted
    ticks(1);
    bad = 1'b0;
    btn = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (i == 5) btn = 1'b0;
      @(negedge clk);
      if (state !== 3'd0) bad = 1'b1;
    end
    check("t4_glitch_ignored", bad, 0);
    check("t4_busy", busy, 0);

    // 5. no landing: timeout after 20 AIR ticks (v = 8 + 2*4 = 16)
    btn = 1'b1;
    wait_state(3'd1, "t5_enter_charge", 100);
    ticks(2);
    btn = 1'b0;
    wait_state(3'd2, "t5_launch", 100);
    exp_pulses++;
    check("t5_vinit", v_init, 16);
    cyc(1);
    check("t5_air", state, 3);
    ticks(19);
    check("t5_air_19", state, 3);
    check("t5_no_to_19", timeout, 0);
    ticks(1);
    check("t5_recover", state, 4);
    check("t5_timeout_set", timeout, 1);
    wait_state(3'd0, "t5_idle", 20);
    check("t5_timeout_sticky", timeout, 1);
    // next launch clears the flag; a done pulse during LAUNCH is ignored
    btn = 1'b1;
    wait_state(3'd1, "t5b_charge", 100);
    check("t5b_to_in_charge", timeout, 1);
    ticks(2);
    btn = 1'b0;
    wait_state(3'd2, "t5b_launch", 100);
    exp_pulses++;
    check("t5b_to_cleared", timeout, 0);
    pulse_done();
    check("t5b_done_in_launch", state, 3);
    cyc(3);
    check("t5b_still_air", state, 3);
    pulse_done();
    wait_state(3'd0, "t5b_idle", 20);
    // done coinciding with the timeout tick: done wins
    btn = 1'b1;
    wait_state(3'd1, "t5c_charge", 100);
    ticks(2);
    btn = 1'b0;
    wait_state(3'd3, "t5c_air", 100);
    exp_pulses++;
    ticks(19);
    while (ph != 2'd3) @(negedge clk);
    pulse_done();
    check("t5c_recover", state, 4);
    check("t5c_done_wins", timeout, 0);
    wait_state(3'd0, "t5c_idle", 20);

    // 6. enable drop mid-charge
    btn = 1'b1;
    wait_state(3'd1, "t6_charge", 100);
    ticks(3);
    en = 1'b0;
    cyc(1);
    check("t6_idle", state, 0);
    check("t6_sq", squeeze, 0);
    check("t6_vinit_kept", v_init, 16);
    en = 1'b1;
    cyc(10);
    check("t6_held_no_rearm", state, 0);
    btn = 1'b0;
    ticks(4);
    // press while disabled is discarded, not deferred
    en  = 1'b0;
    btn = 1'b1;
    ticks(4);
    en = 1'b1;
    cyc(10);
    check("t6_press_discarded", state, 0);
    btn = 1'b0;
    ticks(4);
    check("t6_pulses", pulses, exp_pulses);

    // reset during AIR
    btn = 1'b1;
    wait_state(3'd1, "t7_charge", 100);
    ticks(2);
    btn = 1'b0;
    wait_state(3'd3, "t7_air", 100);
    rst = 1'b1;
    cyc(1);
    check_reset_outputs("t7_rst");
    rst = 1'b0;
    cyc(5);
    check("t7_idle_after", state, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
